// File: rtl/pipelined_adder_pkg.sv
// Shared types and configuration helpers for the pipelined adder.
// Default geometry plus the width/stage legality check used at elaboration.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 2;
  localparam int DEF_CHUNK  = DEF_WIDTH / DEF_STAGES;

  // Contents of one pipeline slice at the default geometry.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic                 carry;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 op_sub;
  } stage_payload_t;

  function automatic int chunk_of(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One register slice of the pipelined adder: resolves chunk IDX of the
// carry chain from the upstream slice and tracks its own valid/ready.
module pipelined_adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_sum,
  input  logic             up_carry,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic             up_op_sub,
  input  logic             down_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             op_sub
);

  logic [CHUNK:0]   part;
  logic [WIDTH-1:0] sum_next;

  assign ready = !valid || down_ready;

  // b arrives already inverted for subtraction, so every chunk is a plain add.
  always_comb begin
    part = {1'b0, up_a[IDX*CHUNK +: CHUNK]}
         + {1'b0, up_b[IDX*CHUNK +: CHUNK]}
         + {{CHUNK{1'b0}}, up_carry};
    sum_next = up_sum;
    sum_next[IDX*CHUNK +: CHUNK] = part[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid  <= 1'b0;
      sum    <= '0;
      carry  <= 1'b0;
      a      <= '0;
      b      <= '0;
      op_sub <= 1'b0;
    end else if (ready) begin
      valid  <= up_valid;
      sum    <= sum_next;
      carry  <= part[CHUNK];
      a      <= up_a;
      b      <= up_b;
      op_sub <= up_op_sub;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with carry-in and valid/ready on both sides.
// Optional output saturation is enabled by defining PIPELINED_ADDER_SAT_EN.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int  CHUNK  = chunk_of(WIDTH, STAGES);
  localparam bit  CFG_OK = cfg_ok(WIDTH, STAGES);

  if (!CFG_OK) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             r       [STAGES+1];
  logic             v       [STAGES];
  logic [WIDTH-1:0] s_sum   [STAGES];
  logic             s_carry [STAGES];
  logic [WIDTH-1:0] s_a     [STAGES];
  logic [WIDTH-1:0] s_b     [STAGES];
  logic             s_op    [STAGES];

  assign r[STAGES] = out_ready;
  assign in_ready  = r[0] && rstn;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_sum;
    logic             up_carry;
    logic [WIDTH-1:0] up_a;
    logic [WIDTH-1:0] up_b;
    logic             up_op;

    if (k == 0) begin : g_head
      // Subtraction is folded in here: a + ~b + ~cin.
      assign up_valid = in_valid && in_ready;
      assign up_sum   = '0;
      assign up_carry = cin ^ op_sub;
      assign up_a     = a;
      assign up_b     = b ^ {WIDTH{op_sub}};
      assign up_op    = op_sub;
    end else begin : g_body
      assign up_valid = v[k-1];
      assign up_sum   = s_sum[k-1];
      assign up_carry = s_carry[k-1];
      assign up_a     = s_a[k-1];
      assign up_b     = s_b[k-1];
      assign up_op    = s_op[k-1];
    end

    pipelined_adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk        (clk),
      .rstn       (rstn),
      .up_valid   (up_valid),
      .up_sum     (up_sum),
      .up_carry   (up_carry),
      .up_a       (up_a),
      .up_b       (up_b),
      .up_op_sub  (up_op),
      .down_ready (r[k+1]),
      .ready      (r[k]),
      .valid      (v[k]),
      .sum        (s_sum[k]),
      .carry      (s_carry[k]),
      .a          (s_a[k]),
      .b          (s_b[k]),
      .op_sub     (s_op[k])
    );
  end

  assign out_valid = v[STAGES-1];
  assign cout      = s_carry[STAGES-1];

`ifdef PIPELINED_ADDER_SAT_EN
  logic unused_tail;
  assign unused_tail = ^{s_a[STAGES-1], s_b[STAGES-1]};

  // Clamp on overflow (add) or underflow (sub); cout stays the raw carry.
  always_comb begin
    sum = s_sum[STAGES-1];
    if (!s_op[STAGES-1] && s_carry[STAGES-1]) begin
      sum = '1;
    end else if (s_op[STAGES-1] && !s_carry[STAGES-1]) begin
      sum = '0;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ^{s_a[STAGES-1], s_b[STAGES-1], s_op[STAGES-1]};
  assign sum = s_sum[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=8, STAGES=2) against a
// queue-based occupancy model plus directed literal expectations.
module tb_pipelined_adder;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;

  always #5 clk = ~clk;

  pipelined_adder dut (
    .clk       (clk),
    .rstn      (rstn),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           pos;
    int           t;
  } item_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           lat;
  } got_t;

  item_t q[$];
  got_t  got[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    opos[S];
  bit    mvd[S];
  logic  eov, eir;

  function automatic logic [W:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rc, input logic rs);
    int           t;
    logic         c;
    logic [W-1:0] s;
    if (!rs) begin
      t = int'(ra) + int'(rb) + int'(rc);
      c = (t > 255);
    end else begin
      t = int'(ra) - int'(rb) - int'(rc);
      c = (t >= 0);
    end
    s = t[W-1:0];
`ifdef PIPELINED_ADDER_SAT_EN
    if (!rs && c) s = '1;
    if (rs && !c) s = '0;
`endif
    return {c, s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each in-flight op has a slot position; an op advances when the
  // slot ahead is empty or its occupant advances; the head leaves on out_ready.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      chk("reset out_valid", {31'b0, out_valid}, 0);
      chk("reset in_ready", {31'b0, in_ready}, 0);
      chk("reset sum", {24'b0, sum}, 0);
      chk("reset cout", {31'b0, cout}, 0);
      q.delete();
    end else begin
      eov = (q.size() > 0) && (q[0].pos == S-1);
      eir = (q.size() < S) || out_ready;
      chk("out_valid", {31'b0, out_valid}, {31'b0, eov});
      chk("in_ready", {31'b0, in_ready}, {31'b0, eir});
      if (eov) begin
        chk("sum", {24'b0, sum}, {24'b0, q[0].s});
        chk("cout", {31'b0, cout}, {31'b0, q[0].c});
      end
      for (int i = 0; i < q.size(); i++) opos[i] = q[i].pos;
      for (int i = 0; i < q.size(); i++) begin
        if (i == 0) mvd[i] = (opos[0] < S-1) || out_ready;
        else        mvd[i] = (opos[i] + 1 < opos[i-1]) || mvd[i-1];
      end
      if (eov && out_ready) got.push_back('{sum, cout, cyc - q[0].t});
      for (int i = 0; i < q.size(); i++) if (mvd[i]) q[i].pos++;
      if (q.size() > 0 && q[0].pos == S) void'(q.pop_front());
      if (in_valid && eir) begin
        logic [W:0] r;
        r = ref_result(a, b, cin, op_sub);
        q.push_back('{r[W-1:0], r[W], 0, cyc});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns likewise after acceptance.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ts);
    int n;
    n = 0;
    a = ta; b = tb; cin = tc; op_sub = ts; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic chk_last(input string name, input logic [W-1:0] es, input logic ec);
    if (got.size() == 0) begin
      chk({name, " present"}, 0, 1);
    end else begin
      chk({name, " sum"}, {24'b0, got[got.size()-1].s}, {24'b0, es});
      chk({name, " cout"}, {31'b0, got[got.size()-1].c}, {31'b0, ec});
    end
  endtask

  int base;

  initial begin
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst literal out_valid", {31'b0, out_valid}, 0);
    chk("rst literal sum", {24'b0, sum}, 0);
    chk("rst literal in_ready", {31'b0, in_ready}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("in_ready after release", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;

    send(8'h7F, 8'h01, 1'b0, 1'b0);
    idle(4);
    chk_last("7F+01", 8'h80, 1'b0);
    if (got.size() > 0) chk("latency", got[got.size()-1].lat, S);

    send(8'hFF, 8'h01, 1'b0, 1'b0);
    idle(4);
`ifdef PIPELINED_ADDER_SAT_EN
    chk_last("FF+01", 8'hFF, 1'b1);
`else
    chk_last("FF+01", 8'h00, 1'b1);
`endif

    send(8'h05, 8'h07, 1'b0, 1'b1);
    idle(4);
`ifdef PIPELINED_ADDER_SAT_EN
    chk_last("05-07", 8'h00, 1'b0);
`else
    chk_last("05-07", 8'hFE, 1'b0);
`endif
    send(8'h07, 8'h05, 1'b1, 1'b1);
    idle(4);
    chk_last("07-05-1", 8'h01, 1'b1);

    // Back-pressure: four ops while the consumer stalls.
    out_ready = 1'b0;
    base = got.size();
    fork
      begin
        send(8'd1, 8'd1, 1'b0, 1'b0);
        send(8'd2, 8'd2, 1'b0, 1'b0);
        send(8'd3, 8'd3, 1'b0, 1'b0);
        send(8'd4, 8'd4, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp in_ready low", {31'b0, in_ready}, 0);
        chk("bp out_valid", {31'b0, out_valid}, 1);
        chk("bp sum held", {24'b0, sum}, 32'h02);
        @(negedge clk);
        chk("bp sum stable", {24'b0, sum}, 32'h02);
        chk("bp still full", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);
    chk("bp count", got.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < got.size())
        chk("bp order", {24'b0, got[base+i].s}, 2 * (i + 1));
    end

    // Mid-flight reset discards in-flight ops.
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b0, 1'b0);
    base = got.size();
    rstn = 1'b0;
    #1;
    chk("async out_valid", {31'b0, out_valid}, 0);
    chk("async in_ready", {31'b0, in_ready}, 0);
    idle(2);
    rstn = 1'b1;
    idle(5);
    chk("no result after reset", got.size(), base);
    send(8'h10, 8'h20, 1'b0, 1'b0);
    idle(4);
    chk_last("post-reset 10+20", 8'h30, 1'b0);
    if (got.size() > 0) chk("post-reset latency", got[got.size()-1].lat, S);

    // Random traffic with random back-pressure.
    repeat (400) begin
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      op_sub    = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(6);
    chk("drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
